// File: rtl/halt_dump_pkg.sv
// halt_dump_pkg: shared types and constants for the halt/dump block.
//   state_e      - dump FSM states
//   HDR_*        - frame header bytes (ebreak halt vs. run-cycle timeout)
//   TRAILER      - final frame byte
//   FRAME_WORDS  - 32-bit words between header and trailer
package halt_dump_pkg;

  typedef enum logic [2:0] {
    RUN,
    LOAD,
    SEND,
    TRAIL,
    DONE
  } state_e;

  localparam logic [7:0] HDR_EBREAK  = 8'hEB;
  localparam logic [7:0] HDR_TIMEOUT = 8'hEE;
  localparam logic [7:0] TRAILER     = 8'h0A;
  localparam int         FRAME_WORDS = 35;
  localparam int         WIDX_W      = 6;

endpackage

// File: rtl/halt_dump_serializer.sv
// dump_serializer: holds one 32-bit word and emits it LSB byte first over a
// valid/ready byte port. A "single" load emits only the low byte (used for
// header and trailer).
//   clk, rst_n     - clock, async active-low reset
//   load           - capture load_data; starts a new word
//   load_single    - word is one byte long
//   load_data      - word to send
//   tx_ready       - sink accepts tx_data this edge when tx_valid is high
//   tx_data/valid  - byte stream
//   last_acc       - final byte of the current word is accepted this edge
module dump_serializer
  import halt_dump_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        load_single,
  input  logic [31:0] load_data,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        last_acc
);

  logic [31:0] sr_q, sr_d;
  logic [1:0]  idx_q, idx_d;
  logic        single_q, single_d;
  logic        busy_q, busy_d;
  logic        acc;

  assign acc      = busy_q & tx_ready;
  assign last_acc = acc & (single_q | (idx_q == 2'd3));
  assign tx_valid = busy_q;
  assign tx_data  = busy_q ? sr_q[7:0] : 8'h00;

  always_comb begin
    sr_d     = sr_q;
    idx_d    = idx_q;
    single_d = single_q;
    busy_d   = busy_q;
    // A load always happens when the port is idle or its last byte is
    // being accepted, so it may safely override the accept path.
    if (load) begin
      sr_d     = load_data;
      idx_d    = 2'd0;
      single_d = load_single;
      busy_d   = 1'b1;
    end else if (acc) begin
      sr_d  = {8'h00, sr_q[31:8]};
      idx_d = idx_q + 2'd1;
      if (last_acc) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q     <= '0;
      idx_q    <= '0;
      single_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      idx_q    <= idx_d;
      single_q <= single_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/halt_dump.sv
// halt_dump: counts run cycles; on an ebreak pulse or run-cycle timeout it
// freezes the core and streams a 142-byte debug frame:
//   header, PC, cycle count lo/hi, x0..x31 (each LE), trailer 0x0A.
//   clk, rst_n        - clock, async active-low reset
//   ebreak_pulse, pc  - halt request and current core PC
//   rf_raddr/rf_rdata - register-file debug read (combinational data)
//   core_stall        - freezes the core while not in RUN
//   tx_data/valid/ready - byte stream
//   dump_done         - frame fully sent, held until reset
module halt_dump
  import halt_dump_pkg::*;
#(
  parameter logic [63:0] TIMEOUT_CYCLES = 64'd5_000_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ebreak_pulse,
  input  logic [31:0] pc,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic        core_stall,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        dump_done
);

  state_e              state_q, state_d;
  logic [63:0]         cnt_q, cnt_d;
  logic [63:0]         cnt_lat_q, cnt_lat_d;
  logic [31:0]         pc_lat_q, pc_lat_d;
  logic                hdr_q, hdr_d;     // header byte still in flight
  logic [WIDX_W-1:0]   widx_q, widx_d;   // frame word index 0..34

  logic        ld, ld_single, last_acc;
  logic [31:0] ld_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cnt_lat_d = cnt_lat_q;
    pc_lat_d  = pc_lat_q;
    hdr_d     = hdr_q;
    widx_d    = widx_q;
    ld        = 1'b0;
    ld_single = 1'b0;
    ld_data   = '0;
    rf_raddr  = '0;
    case (state_q)
      RUN: begin
        cnt_d = cnt_q + 64'd1;
        if (ebreak_pulse || (cnt_q == TIMEOUT_CYCLES - 64'd1)) begin
          pc_lat_d  = pc;
          cnt_lat_d = cnt_q;
          ld        = 1'b1;
          ld_single = 1'b1;
          ld_data   = {24'h0, ebreak_pulse ? HDR_EBREAK : HDR_TIMEOUT};
          hdr_d     = 1'b1;
          widx_d    = '0;
          state_d   = SEND;
        end
      end
      LOAD: begin
        ld = 1'b1;
        case (widx_q)
          WIDX_W'(0): ld_data = pc_lat_q;
          WIDX_W'(1): ld_data = cnt_lat_q[31:0];
          WIDX_W'(2): ld_data = cnt_lat_q[63:32];
          default: begin
            rf_raddr = 5'(widx_q - WIDX_W'(3));
            ld_data  = rf_rdata;
          end
        endcase
        state_d = SEND;
      end
      SEND: begin
        if (last_acc) begin
          if (hdr_q) begin
            hdr_d   = 1'b0;
            state_d = LOAD;
          end else if (widx_q == WIDX_W'(FRAME_WORDS - 1)) begin
            // Trailer is loaded on the last accept so no bubble precedes it.
            ld        = 1'b1;
            ld_single = 1'b1;
            ld_data   = {24'h0, TRAILER};
            state_d   = TRAIL;
          end else begin
            widx_d  = widx_q + WIDX_W'(1);
            state_d = LOAD;
          end
        end
      end
      TRAIL: begin
        if (last_acc) state_d = DONE;
      end
      default: ;  // DONE: everything frozen
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      cnt_lat_q <= '0;
      pc_lat_q  <= '0;
      hdr_q     <= 1'b0;
      widx_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cnt_lat_q <= cnt_lat_d;
      pc_lat_q  <= pc_lat_d;
      hdr_q     <= hdr_d;
      widx_q    <= widx_d;
    end
  end

  assign core_stall = (state_q != RUN);
  assign dump_done  = (state_q == DONE);

  dump_serializer u_ser (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (ld),
    .load_single(ld_single),
    .load_data  (ld_data),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .last_acc   (last_acc)
  );

endmodule

// File: tb/tb_halt_dump.sv
module tb_halt_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, ebreak, tx_ready, rnd_mode, sel;
  logic [31:0] pc;

  logic [4:0]  rf_raddr_a, rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic        core_stall_a, core_stall_b, tx_valid_a, tx_valid_b;
  logic        dump_done_a, dump_done_b;
  logic [7:0]  tx_data_a, tx_data_b;

  function automatic logic [31:0] rf_val(input logic [4:0] i);
    if (i == 5'd0) return 32'h0;
    if (i == 5'd1) return 32'h1234_5678;
    return {3'b101, i, ~{3'b000, i}, 8'h30 + {3'b000, i}, i, 3'b011};
  endfunction

  assign rf_rdata_a = rf_val(rf_raddr_a);
  assign rf_rdata_b = rf_val(rf_raddr_b);

  halt_dump dut_a (
    .clk(clk), .rst_n(rst_a), .ebreak_pulse(ebreak), .pc(pc),
    .rf_raddr(rf_raddr_a), .rf_rdata(rf_rdata_a), .core_stall(core_stall_a),
    .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
    .dump_done(dump_done_a)
  );

  halt_dump #(.TIMEOUT_CYCLES(64'd50)) dut_b (
    .clk(clk), .rst_n(rst_b), .ebreak_pulse(ebreak), .pc(pc),
    .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b), .core_stall(core_stall_b),
    .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
    .dump_done(dump_done_b)
  );

  logic       m_rst, m_valid, m_done, m_stall;
  logic [7:0] m_data;
  assign m_rst   = sel ? rst_b        : rst_a;
  assign m_valid = sel ? tx_valid_b   : tx_valid_a;
  assign m_data  = sel ? tx_data_b    : tx_data_a;
  assign m_done  = sel ? dump_done_b  : dump_done_a;
  assign m_stall = sel ? core_stall_b : core_stall_a;

  int checks = 0, errors = 0, nrx = 0;
  logic [7:0] q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
  endtask

  task automatic push_frame(input logic [7:0] hdr, input logic [31:0] p, input logic [63:0] cnt);
    q.delete();
    nrx = 0;
    q.push_back(hdr);
    push_word(p);
    push_word(cnt[31:0]);
    push_word(cnt[63:32]);
    for (int r = 0; r < 32; r++) push_word(rf_val(5'(r)));
    q.push_back(8'h0A);
  endtask

  task automatic wait_done(input int exp_cyc, input bit chk_cyc);
    int cyc = 0;
    while (!m_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    if (chk_cyc) chk("done_cycles", 64'(cyc), 64'(exp_cyc));
    else         chk("done_reached", 64'(m_done), 64'd1);
    chk("queue_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic ebreak_pulse_now();
    ebreak = 1'b1;
    @(negedge clk);
    ebreak = 1'b0;
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_stall"}, 64'(core_stall_a), 64'd0);
    chk({tag, "_valid"}, 64'(tx_valid_a),   64'd0);
    chk({tag, "_data"},  64'(tx_data_a),    64'd0);
    chk({tag, "_raddr"}, 64'(rf_raddr_a),   64'd0);
    chk({tag, "_done"},  64'(dump_done_a),  64'd0);
  endtask

  // Sink handshake: always ready, or random back-pressure.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      tx_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops expected bytes on every transfer, checks hold during stalls.
  initial begin
    logic       pstall;
    logic [7:0] pdata, exp;
    pstall = 1'b0;
    pdata  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!m_rst) pstall = 1'b0;
      else begin
        if (pstall) begin
          checks++;
          if (!m_valid || m_data !== pdata) begin
            errors++;
            $display("FAIL hold act_v=%0b act=%0h exp=%0h", m_valid, m_data, pdata);
          end
        end
        if (m_valid && tx_ready) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte act=%0h exp=none", m_data);
          end else begin
            exp = q.pop_front();
            chk($sformatf("byte%0d", nrx), 64'(m_data), 64'(exp));
            nrx++;
          end
        end
        pstall = m_valid && !tx_ready;
        pdata  = m_data;
      end
    end
  end

  initial begin
    int cyc;
    rst_a = 1'b0; rst_b = 1'b0; ebreak = 1'b0; pc = 32'h0000_0040;
    rnd_mode = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_a("reset");

    // Ebreak at counter 100, sink always ready.
    rst_a = 1'b1;
    repeat (100) @(negedge clk);
    chk("stall_before", 64'(core_stall_a), 64'd0);
    push_frame(8'hEB, 32'h40, 64'd100);
    ebreak_pulse_now();
    chk("stall_after", 64'(core_stall_a), 64'd1);
    wait_done(177, 1'b1);
    chk("stall_done", 64'(core_stall_a), 64'd1);
    ebreak_pulse_now();
    repeat (5) @(negedge clk);
    chk("done_hold", 64'(dump_done_a), 64'd1);
    chk("done_novalid", 64'(tx_valid_a), 64'd0);

    // Same run with random back-pressure and an ebreak during SEND.
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    rnd_mode = 1'b1;
    repeat (100) @(negedge clk);
    push_frame(8'hEB, 32'h40, 64'd100);
    ebreak_pulse_now();
    repeat (30) @(negedge clk);
    ebreak_pulse_now();
    wait_done(0, 1'b0);
    ebreak_pulse_now();
    repeat (3) @(negedge clk);
    chk("bp_done_hold", 64'(dump_done_a), 64'd1);
    rnd_mode = 1'b0;

    // Reset mid-frame, then a fresh halt at counter 5.
    rst_a = 1'b0;
    @(negedge clk);
    rst_a = 1'b1;
    repeat (100) @(negedge clk);
    push_frame(8'hEB, 32'h40, 64'd100);
    ebreak_pulse_now();
    cyc = 0;
    while (nrx < 20 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_byte20", 64'(nrx >= 20), 64'd1);
    rst_a = 1'b0;
    q.delete();
    #1;
    chk_idle_a("midrst");
    repeat (2) @(negedge clk);
    rst_a = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_valid", 64'(tx_valid_a), 64'd0);
    chk("post_rst_stall", 64'(core_stall_a), 64'd0);
    push_frame(8'hEB, 32'h40, 64'd5);
    ebreak_pulse_now();
    wait_done(177, 1'b1);

    // Timeout instance: no ebreak, forced dump at counter 49.
    rst_a = 1'b0;
    sel = 1'b1;
    @(negedge clk);
    push_frame(8'hEE, 32'h40, 64'd49);
    rst_b = 1'b1;
    repeat (49) @(negedge clk);
    chk("to_stall_49", 64'(m_stall), 64'd0);
    @(negedge clk);
    chk("to_stall_50", 64'(m_stall), 64'd1);
    wait_done(0, 1'b0);

    // Ebreak coincident with the timeout cycle: ebreak header wins.
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    repeat (49) @(negedge clk);
    push_frame(8'hEB, 32'h40, 64'd49);
    ebreak_pulse_now();
    wait_done(177, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/halt_dump.md
HALT_DUMP -- requirements
Module: halt_dump

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64'd5_000_000_000, the run-cycle limit before a forced dump.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port ebreak_pulse  input  1  one-cycle halt request from the core.
REQ-005 SHALL have port pc  input  32  current core PC.
REQ-006 SHALL have port rf_raddr  output  5  register-file debug read address.
REQ-007 SHALL have port rf_rdata  input  32  register-file debug read data, combinational from rf_raddr.
REQ-008 SHALL have port core_stall  output  1  freezes the core (no PC or register update) while high.
REQ-009 SHALL have port tx_data  output  8  dump byte stream.
REQ-010 SHALL have port tx_valid  output  1  tx_data valid.
REQ-011 SHALL have port tx_ready  input  1  sink accepts byte; transfer occurs when tx_valid and tx_ready are both high at a clock edge.
REQ-012 SHALL have port dump_done  output  1  frame fully sent; held until reset.

Function
REQ-013 SHALL implement states RUN, LOAD, SEND, TRAIL, DONE.
REQ-014 RUN: 64-bit cycle counter SHALL increment by 1 every clock; core_stall=0, tx_valid=0.
REQ-015 RUN, ebreak_pulse=1: SHALL latch pc and the pre-increment counter value, set header 0xEB, assert core_stall on the next cycle, and go to SEND with the header byte.
REQ-016 RUN, counter==TIMEOUT_CYCLES-1 with no ebreak: SHALL latch the same fields with header 0xEE and go to SEND; ebreak in the same cycle wins (header 0xEB).
REQ-017 ebreak_pulse outside RUN SHALL be ignored.
REQ-018 Frame SHALL be: header byte, then 35 words each little-endian (4 bytes): latched PC, cycle count low, cycle count high, x0..x31, then trailer 0x0A; 142 bytes total.
REQ-019 LOAD SHALL take one cycle: it drives rf_raddr=word_index-3 for register words and captures rf_rdata (or latched PC/count) into a 32-bit shift register, then returns to SEND.
REQ-020 SEND: tx_valid=1; tx_data SHALL remain stable until accepted; each accept advances byte index 0..3, and after byte 3 it goes to LOAD for the next word, or to TRAIL after word 34.
REQ-021 tx_ready asserted continuously SHALL give one byte per cycle except for one LOAD bubble per word (177 cycles from halt to dump_done, excluding back-pressure).
REQ-022 TRAIL: SHALL send 0x0A; on accept it goes to DONE.
REQ-023 DONE: dump_done=1, core_stall=1, tx_valid=0, and the counter is frozen.
REQ-024 core_stall SHALL remain 1 in LOAD, SEND, TRAIL and DONE.
REQ-025 rf_raddr SHALL be 0 outside LOAD.
REQ-026 Back-pressure (tx_ready low for any number of cycles) SHALL NOT drop, duplicate or alter bytes.

Reset
REQ-027 rst_n low SHALL asynchronously force state RUN, counter 0, core_stall 0, tx_valid 0, tx_data 0, rf_raddr 0, dump_done 0, and clear all latches and indices.
REQ-028 Reset asserted mid-frame SHALL abort the frame; after release a new run starts with counter 0 and no residual bytes.

Structure
REQ-029 Shared package SHALL hold the state enum, HDR_EBREAK=8'hEB, HDR_TIMEOUT=8'hEE, TRAILER=8'h0A, FRAME_WORDS=35.
REQ-030 SHALL instantiate one sub-module, dump_serializer (32-bit word to 4-byte little-endian valid/ready shifter); the FSM and counter stay in halt_dump.

Verification
REQ-031 Release reset, pulse ebreak_pulse at counter 100 with pc=0x0000_0040, x1=0x1234_5678, tx_ready=1 -> 142 bytes: EB 40 00 00 00 64 00.., x1 bytes 78 56 34 12, trailer 0A; dump_done 177 cycles after the pulse.
REQ-032 Same run with tx_ready toggled randomly -> byte sequence identical to REQ-031 and tx_data stable during every stall.
REQ-033 TIMEOUT_CYCLES=50, no ebreak -> header 0xEE, cycle count 49, core_stall rises after counter 49.
REQ-034 ebreak_pulse coincident with the timeout cycle -> header 0xEB.
REQ-035 ebreak_pulse in DONE and in SEND -> no change to the frame, dump_done stays 1.
REQ-036 rst_n low after byte 20, then a new ebreak at counter 5 -> all outputs 0 during reset, new frame starts with EB and count 5.
